// File: rtl/data_synchronizer_if.sv
// Purpose : byte-bus handshake bundle between an asynchronous producer and data_synchronizer.
// Latency : none (wires only).
// Backpr. : none; dready_i is a level strobe and dready_o a one-cycle pulse, no ready path.
//
// Signals:
//   din      producer data, stable while dready_i is high
//   dready_i producer level strobe, asynchronous to clk
//   dout     captured word, registered in the clk domain
//   dready_o one-cycle pulse marking a new dout value
// master = producer/consumer side (bench or surrounding logic), slave = data_synchronizer.
interface data_synchronizer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] din;
    logic              dready_i;
    logic [DATA_W-1:0] dout;
    logic              dready_o;

    modport master (
        output din,
        output dready_i,
        input  dout,
        input  dready_o
    );

    modport slave (
        input  din,
        input  dready_i,
        output dout,
        output dready_o
    );
endinterface

// File: rtl/data_synchronizer.sv
// Purpose : synchronise an asynchronous level strobe and capture one data word per rising level.
// Latency : dready_o/dout update SYNC_STAGES clk edges after dready_i is first sampled high.
// Backpr. : none; a level held high gives one pulse, a pulse shorter than a clk period may be lost.
//
// Ports:
//   clk  system clock, all state on rising edge
//   rstn synchronous reset, active HIGH despite the name (1 = reset)
//   bus  data_synchronizer_if.slave: din, dready_i in; dout, dready_o out
// Optional build macro DATA_SYNC_DIN_DELAY_EN: when defined, din is delayed through a
// SYNC_STAGES-deep pipeline so dout holds the word present when dready_i was first sampled.
module data_synchronizer #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2   // legal range 2..4
) (
    input  logic                clk,
    input  logic                rstn,
    data_synchronizer_if.slave  bus
);

    // sync_q[0] may go metastable; only the last stage feeds logic.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [DATA_W-1:0]      dout_q,     dout_d;
    logic                   dready_o_q, dready_o_d;
    logic                   ds;
    logic                   rise;
    logic [DATA_W-1:0]      cap_dat;

    assign ds   = sync_q[SYNC_STAGES-1];
    assign rise = ds & ~prev_q;

`ifdef DATA_SYNC_DIN_DELAY_EN
    // Data travels alongside the strobe so the captured word is the one seen
    // on the same edge where dready_i was first sampled high.
    logic [DATA_W-1:0] dly_q [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            dly_q[0] <= bus.din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign cap_dat = dly_q[SYNC_STAGES-1];
`else
    assign cap_dat = bus.din;
`endif

    always_comb begin
        dout_d     = dout_q;
        dready_o_d = 1'b0;
        if (rise) begin
            dout_d     = cap_dat;
            dready_o_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            dout_q     <= '0;
            dready_o_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.dready_i};
            prev_q     <= ds;
            dout_q     <= dout_d;
            dready_o_q <= dready_o_d;
        end
    end

    assign bus.dout     = dout_q;
    assign bus.dready_o = dready_o_q;

endmodule

// File: tb/tb_data_synchronizer.sv
// Purpose : directed self-checking bench for data_synchronizer.
// Latency : inputs driven and outputs sampled 1ns after each rising clk edge.
// Backpr. : n/a.
module tb_data_synchronizer;

    localparam int DW = 8;
    localparam int SS = 2;

    logic clk;
    logic rstn;
    int   total;
    int   bad;
    int   pulses;

    data_synchronizer_if #(.DATA_W(DW)) bus ();

    data_synchronizer #(
        .DATA_W      (DW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clk edge, then look at the outputs 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.dready_o === 1'b1) pulses++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [DW-1:0] exp4;

    initial begin
        total = 0;
        bad   = 0;
        pulses = 0;
`ifdef DATA_SYNC_DIN_DELAY_EN
        exp4 = 8'hFF;
`else
        exp4 = 8'h00;
`endif
        rstn         = 1'b1;
        bus.din      = 8'h00;
        bus.dready_i = 1'b0;
        ticks(3);
        chk("rst_dout", {24'h0, bus.dout}, 32'h00);
        chk("rst_vld",  {31'h0, bus.dready_o}, 32'h0);
        rstn = 1'b0;

        // 1: idle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_vld",  {31'h0, bus.dready_o}, 32'h0);
            chk("idle_dout", {24'h0, bus.dout}, 32'h00);
        end

        // 2: 0xAA, strobe high for 2 samples
        bus.din = 8'hAA;
        bus.dready_i = 1'b1;
        tick();                                   // E0
        chk("c2_e0_vld", {31'h0, bus.dready_o}, 32'h0);
        tick();                                   // E1
        chk("c2_e1_vld", {31'h0, bus.dready_o}, 32'h0);
        bus.dready_i = 1'b0;
        tick();                                   // E2: capture
        chk("c2_e2_vld",  {31'h0, bus.dready_o}, 32'h1);
        chk("c2_e2_dout", {24'h0, bus.dout}, 32'hAA);
        tick();
        chk("c2_e3_vld", {31'h0, bus.dready_o}, 32'h0);
        ticks(3);
        chk("c2_pulses", pulses, 1);

        // 3: data changes without a strobe
        bus.din = 8'h55;
        ticks(5);
        chk("c3_dout",   {24'h0, bus.dout}, 32'hAA);
        chk("c3_pulses", pulses, 1);

        // 4: din changes while strobe stays high
        bus.din = 8'hFF;
        bus.dready_i = 1'b1;
        ticks(2);                                 // E0, E1
        bus.din = 8'h00;
        tick();                                   // E2: capture
        chk("c4_vld",  {31'h0, bus.dready_o}, 32'h1);
        chk("c4_dout", {24'h0, bus.dout}, {24'h0, exp4});
        tick();
        bus.dready_i = 1'b0;
        ticks(4);
        chk("c4_pulses", pulses, 2);
        chk("c4_hold",   {24'h0, bus.dout}, {24'h0, exp4});

        // 5: long level, then one-cycle gap and a second word
        bus.din = 8'h3C;
        bus.dready_i = 1'b1;
        ticks(20);
        chk("c5_long_pulses", pulses, 3);
        chk("c5_long_dout",   {24'h0, bus.dout}, 32'h3C);
        bus.dready_i = 1'b0;
        tick();                                   // sampled low once
        bus.din = 8'hC3;
        bus.dready_i = 1'b1;
        ticks(SS);                                // E0 .. E(SS-1)
        chk("c5_pre_vld", {31'h0, bus.dready_o}, 32'h0);
        tick();                                   // E(SS)
        chk("c5_vld",  {31'h0, bus.dready_o}, 32'h1);
        chk("c5_dout", {24'h0, bus.dout}, 32'hC3);
        bus.dready_i = 1'b0;
        ticks(4);
        chk("c5_pulses", pulses, 4);

        // 6: reset lands on the capture edge
        bus.din = 8'h99;
        bus.dready_i = 1'b1;
        ticks(SS);                                // E0 .. E(SS-1)
        rstn = 1'b1;
        tick();                                   // would-be capture edge
        chk("c6_rst_vld",  {31'h0, bus.dready_o}, 32'h0);
        chk("c6_rst_dout", {24'h0, bus.dout}, 32'h00);
        rstn = 1'b0;
        for (int i = 0; i < SS; i++) begin
            tick();
            chk("c6_refill_vld", {31'h0, bus.dready_o}, 32'h0);
        end
        tick();
        chk("c6_vld",  {31'h0, bus.dready_o}, 32'h1);
        chk("c6_dout", {24'h0, bus.dout}, 32'h99);
        tick();
        chk("c6_after_vld", {31'h0, bus.dready_o}, 32'h0);
        bus.dready_i = 1'b0;
        ticks(4);
        chk("c6_pulses", pulses, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
